mips_div_unit: RTL and testbench

Iterative multi-cycle integer divider for the MIPS datapath: the inverse counterpart of the single-cycle ALU multiply. Accepts dividend/divisor with a start pulse, runs a radix-2 restoring division one quotient bit per cycle, and returns quotient and remainder with a one-cycle done pulse. Sits beside the ALU in the execute stage and feeds the HI/LO registers; the controller stalls on Busy.

---
 rtl/mips_div_if.sv | 25 ++
 rtl/mips_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mips_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_div_if.sv
// Handshake and operand/result bundle between the execute-stage controller
// (master) and the iterative divider (slave).
interface mips_div_if #(
    parameter int width = 32
);
    logic             Start;
    logic             Signed_op;
    logic [width-1:0] SrcA;
    logic [width-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [width-1:0] Quotient;
    logic [width-1:0] Remainder;
    logic             DivZero_flag;

    modport master (
        output Start, Signed_op, SrcA, SrcB,
        input  Busy, Done, Quotient, Remainder, DivZero_flag
    );

    modport slave (
        input  Start, Signed_op, SrcA, SrcB,
        output Busy, Done, Quotient, Remainder, DivZero_flag
    );
endinterface

// File: rtl/mips_div_unit.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Optional signed support is enabled by defining DIV_SIGNED_EN; without it
// Signed_op is ignored and every divide is unsigned.
//
// state | meaning
// IDLE  | waiting for Start
// CALC  | shifting/subtracting, one quotient bit per cycle (Busy)
// DONE  | results valid, one-cycle Done pulse; Start may re-launch here
module mips_div_unit #(
    parameter int width = 32
) (
    input  logic       clk,
    input  logic       rst,
    mips_div_if.slave  bus
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_q, state_d;

    logic [width-1:0] rem_q;
    logic [width-1:0] quo_q;
    logic [width-1:0] divisor_q;
    logic [CW-1:0]    cnt_q;

    logic [width-1:0] quotient_q;
    logic [width-1:0] remainder_q;
    logic             divzero_q;

    logic [width-1:0] a_mag;
    logic [width-1:0] b_mag;

    logic [width:0]   rem_sh;
    logic [width:0]   trial;
    logic [width-1:0] rem_nx;
    logic [width-1:0] quo_nx;
    logic [width-1:0] quo_fin;
    logic [width-1:0] rem_fin;

    logic             src_b_zero;
    logic             last_step;

    assign src_b_zero = (bus.SrcB == '0);
    assign last_step  = (cnt_q == CW'(1));

`ifdef DIV_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic sign_a;
    logic sign_b;

    // Operand magnitudes and result-sign flags for a signed request
    always_comb begin
        sign_a = bus.Signed_op & bus.SrcA[width-1];
        sign_b = bus.Signed_op & bus.SrcB[width-1];
        a_mag  = sign_a ? (~bus.SrcA + 1'b1) : bus.SrcA;
        b_mag  = sign_b ? (~bus.SrcB + 1'b1) : bus.SrcB;
    end

    // Sign-correction flags, captured alongside the operands
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (bus.Start && state_q != CALC) begin
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
        end
    end

    // Apply the captured signs to the unsigned magnitude results
    always_comb begin
        quo_fin = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
        rem_fin = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = bus.Signed_op;
    assign a_mag            = bus.SrcA;
    assign b_mag            = bus.SrcB;
    assign quo_fin          = quo_nx;
    assign rem_fin          = rem_nx;
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor
    always_comb begin
        rem_sh = {rem_q, quo_q[width-1]};
        trial  = rem_sh - {1'b0, divisor_q};
        if (!trial[width]) begin
            rem_nx = trial[width-1:0];
            quo_nx = {quo_q[width-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[width-1:0];
            quo_nx = {quo_q[width-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; Start is only honoured outside CALC
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) state_d = src_b_zero ? DONE : CALC;
                else           state_d = IDLE;
            end
            CALC:    if (last_step) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        bus.Busy = (state_q == CALC);
        bus.Done = (state_q == DONE);
    end

    // Working registers and result registers; results only change on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divzero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        if (src_b_zero) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.SrcA;
                            divzero_q   <= 1'b1;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= a_mag;
                            divisor_q <= b_mag;
                            cnt_q     <= CW'(width);
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (last_step) begin
                        quotient_q  <= quo_fin;
                        remainder_q <= rem_fin;
                        divzero_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Quotient     = quotient_q;
    assign bus.Remainder    = remainder_q;
    assign bus.DivZero_flag = divzero_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: directed cases plus randomized
// operands compared against a plain-arithmetic reference model.
// Follows the DIV_SIGNED_EN setting used for the build.
module tb_mips_div_unit;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mips_div_if #(.width(W)) bus();

    mips_div_unit #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
`ifdef DIV_SIGNED_EN
            if (s) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
            end
`endif
        end
    endfunction

    // Called at a negedge; returns one negedge later (cycle 1 after the accepting edge)
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.Start     = 1'b1;
        bus.SrcA      = a;
        bus.SrcB      = b;
        bus.Signed_op = s;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
    endtask

    // Counts cycles until Done; optionally pokes a Start at cycle 'poke'
    task automatic wait_done(input int poke, input logic [31:0] pa, input logic [31:0] pb,
                             output int done_cyc, output int busy_cnt);
        int cyc;
        cyc      = 1;
        busy_cnt = 0;
        done_cyc = -1;
        while (cyc < 100) begin
            if (bus.Done) begin
                done_cyc = cyc;
                break;
            end
            if (bus.Busy) busy_cnt++;
            if (cyc == poke) begin
                bus.Start = 1'b1;
                bus.SrcA  = pa;
                bus.SrcB  = pb;
            end else begin
                bus.Start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.Start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input int poke, input logic [31:0] pa, input logic [31:0] pb);
        int dc;
        int bc;
        launch(a, b, s);
        wait_done(poke, pa, pb, dc, bc);
        check({tag, ".done_cycle"}, dc, (b == 0) ? 32'd1 : W + 1);
        check({tag, ".busy_cycles"}, bc, (b == 0) ? 32'd0 : W);
        check({tag, ".quotient"}, bus.Quotient, eq);
        check({tag, ".remainder"}, bus.Remainder, er);
        check({tag, ".divzero"}, {31'd0, bus.DivZero_flag}, {31'd0, (b == 0)});
        @(negedge clk);
        check({tag, ".done_one_cycle"}, {30'd0, bus.Done, bus.Busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          dc;
        int          bc;
        int          done_seen;

        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.Signed_op = 1'b0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset.outputs", {bus.Busy, bus.Done, bus.DivZero_flag}, 32'd0);
        check("reset.quotient", bus.Quotient, 32'd0);
        check("reset.remainder", bus.Remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("unsigned_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0, 0, 0);
        run_op("divzero", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 0, 0, 0);
`ifdef DIV_SIGNED_EN
        run_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("signed_minneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 0, 0, 0);
        run_op("signed_divzero", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0, 0, 0);
`else
        run_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 0, 0, 0);
`endif
        run_op("start_while_busy", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 10, 32'd50, 32'd5);

        // Back-to-back: second Start issued in the Done cycle of the first
        launch(32'd100, 32'd7, 1'b0);
        wait_done(0, 0, 0, dc, bc);
        check("b2b.first_done_cycle", dc, W + 1);
        check("b2b.first_quotient", bus.Quotient, 32'd14);
        launch(32'd50, 32'd5, 1'b0);
        check("b2b.busy_no_gap", {31'd0, bus.Busy}, 32'd1);
        check("b2b.held_quotient", bus.Quotient, 32'd14);
        check("b2b.held_remainder", bus.Remainder, 32'd2);
        wait_done(0, 0, 0, dc, bc);
        check("b2b.second_done_cycle", dc, W + 1);
        check("b2b.second_quotient", bus.Quotient, 32'd10);
        check("b2b.second_remainder", bus.Remainder, 32'd0);
        @(negedge clk);

        // Reset mid-CALC discards the operation and clears held results
        launch(32'd100, 32'd7, 1'b0);
        for (int i = 1; i < 15; i++) @(negedge clk);
        check("midreset.busy_before", {31'd0, bus.Busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset.status", {bus.Busy, bus.Done, bus.DivZero_flag}, 32'd0);
        check("midreset.quotient", bus.Quotient, 32'd0);
        check("midreset.remainder", bus.Remainder, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.Done || bus.Busy) done_seen++;
            @(negedge clk);
        end
        check("midreset.no_done", done_seen, 32'd0);
        run_op("after_reset_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 0, 0, 0);

        // Reset and Start on the same edge: reset wins
        bus.Start = 1'b1;
        bus.SrcA  = 32'd77;
        bus.SrcB  = 32'd0;
        rst       = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        rst       = 1'b0;
        check("rst_vs_start.status", {bus.Busy, bus.Done, bus.DivZero_flag}, 32'd0);
        check("rst_vs_start.remainder", bus.Remainder, 32'd0);
        @(negedge clk);
        check("rst_vs_start.idle", {bus.Busy, bus.Done}, 32'd0);

        // Randomized operands against the reference model
        for (int n = 0; n < 25; n++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            model(a, b, s, q, r);
            run_op($sformatf("rand%0d", n), a, b, s, q, r, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
